// File: rtl/addsub_pkg.sv
// Shared encodings and flag bundle for the pipelined add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/addsub_seg.sv
// Combinational SEG_W-bit ripple adder slice with carry in/out.
module addsub_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             c_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             c_o
);

  logic [SEG_W:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = c_i;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = carry[SEG_W];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: one register stage per SEG_W-bit carry segment,
// valid/ready stream handshake, flags registered alongside the result.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned STAGES = WIDTH / SEG_W;
  localparam int unsigned LAST   = STAGES - 1;

  if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W) begin : g_width_check
    $error("addsub_pipe: WIDTH must be a non-zero multiple of SEG_W");
  end

  op_e              op_sel;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  // stg_* are the inputs seen by stage k; *_q are the registers after stage k
  logic [WIDTH-1:0] stg_a   [STAGES];
  logic [WIDTH-1:0] stg_b   [STAGES];
  logic [WIDTH-1:0] stg_s   [STAGES];
  logic [WIDTH-1:0] stg_res [STAGES];
  logic             stg_c   [STAGES];
  logic             stg_v   [STAGES];
  logic [SEG_W-1:0] seg_sum [STAGES];
  logic             seg_co  [STAGES];

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  flags_t flags_d, flags_q;

  always_comb begin
    op_sel = op_e'(op);
    b_eff  = b;
    c0     = 1'b0;
    case (op_sel)
      OP_ADD:  begin b_eff = b;  c0 = 1'b0; end
      OP_SUB:  begin b_eff = ~b; c0 = 1'b1; end
      OP_ADC:  begin b_eff = b;  c0 = cin;  end
      OP_SBB:  begin b_eff = ~b; c0 = ~cin; end
      default: ;
    endcase
  end

  always_comb begin
    stg_a[0] = a;
    stg_b[0] = b_eff;
    stg_s[0] = '0;
    stg_c[0] = c0;
    stg_v[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      stg_a[k] = a_q[k-1];
      stg_b[k] = b_q[k-1];
      stg_s[k] = s_q[k-1];
      stg_c[k] = c_q[k-1];
      stg_v[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .a_i   (stg_a[k][k*SEG_W +: SEG_W]),
      .b_i   (stg_b[k][k*SEG_W +: SEG_W]),
      .c_i   (stg_c[k]),
      .sum_o (seg_sum[k]),
      .c_o   (seg_co[k])
    );
  end

  // Merge each segment's sum into the low bits already resolved upstream
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      stg_res[k]                  = stg_s[k];
      stg_res[k][k*SEG_W +: SEG_W] = seg_sum[k];
    end
  end

  always_comb begin
    flags_d.cout = seg_co[LAST];
    flags_d.ovf  = (stg_a[LAST][WIDTH-1] == stg_b[LAST][WIDTH-1]) &
                   (stg_res[LAST][WIDTH-1] != stg_a[LAST][WIDTH-1]);
    flags_d.zero = (stg_res[LAST] == '0);
    flags_d.neg  = stg_res[LAST][WIDTH-1];
  end

  assign adv = ~v_q[LAST] | out_ready;

  // Data registers load only on valid beats so bubbles leave s/flags untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      flags_q <= '0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= stg_v[k];
        if (stg_v[k]) begin
          a_q[k] <= stg_a[k];
          b_q[k] <= stg_b[k];
          s_q[k] <= stg_res[k];
          c_q[k] <= seg_co[k];
        end
      end
      if (stg_v[LAST]) flags_q <= flags_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign s         = s_q[LAST];
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed + scoreboard bench for addsub_pipe (WIDTH=8, SEG_W=4).
`timescale 1ns/1ps
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int WIDTH = 8;
  localparam int SEG_W = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, cin;
  logic       cout, ovf, zero, neg;
  logic [7:0] a, b, s;
  logic [1:0] op;

  int checks  = 0;
  int errors  = 0;
  int popped  = 0;
  int run     = 0;
  int max_run = 0;
  int pop_before;
  logic [11:0] q[$];
  logic [11:0] exp_beat;
  logic [1:0]  r_op;
  logic [7:0]  r_a, r_b;
  logic        r_c;

  addsub_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: {s[7:0], cout, ovf, zero, neg}
  function automatic logic [11:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                        input logic ci);
    logic [7:0] ye;
    logic       c;
    logic [8:0] full;
    logic [7:0] r;
    ye = (o == 2'b01 || o == 2'b11) ? ~y : y;
    case (o)
      2'b00:   c = 1'b0;
      2'b01:   c = 1'b1;
      2'b10:   c = ci;
      default: c = ~ci;
    endcase
    full = {1'b0, x} + {1'b0, ye} + {8'd0, c};
    r = full[7:0];
    return {r, full[8], (x[7] == ye[7]) && (r[7] != x[7]), r == 8'd0, r[7]};
  endfunction

  // Scoreboard consumer: every output transfer pops and compares one expected beat
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      run++;
      if (run > max_run) max_run = run;
      popped++;
      check("beat_expected", 16'(q.size() != 0), 16'd1);
      if (q.size() != 0) begin
        exp_beat = q.pop_front();
        check("result", {4'h0, s, cout, ovf, zero, neg}, {4'h0, exp_beat});
      end
    end else begin
      run = 0;
    end
  end

  // Entered at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, input logic ci,
                      input logic [11:0] exp);
    bit accepted = 1'b0;
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        q.push_back(exp);
      end
      @(posedge clk);
      #1;
    end
    check("send_accepted", 16'(accepted), 16'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(tag, 16'(q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $error("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'b00; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_outputs", {4'h0, s, cout, ovf, zero, neg}, 16'h0000);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    @(posedge clk); #1;

    // First beat with explicit 2-cycle latency check
    send(OP_ADD, 8'h04, 8'h01, 1'b0, {8'h05, 4'b0000});
    idle();
    @(negedge clk); check("lat_edge1", 16'(out_valid), 16'd0);
    @(negedge clk); check("lat_edge2", 16'(out_valid), 16'd1);
    @(posedge clk); #1;
    drain("drain_first");

    // Directed corner cases, issued back to back
    send(OP_SUB, 8'h04, 8'h02, 1'b0, {8'h02, 4'b1000});
    send(OP_SUB, 8'h00, 8'h01, 1'b0, {8'hFF, 4'b0001});
    send(OP_SUB, 8'h80, 8'h01, 1'b0, {8'h7F, 4'b1100});
    send(OP_ADD, 8'h7F, 8'h01, 1'b0, {8'h80, 4'b0101});
    send(OP_ADC, 8'hFF, 8'h00, 1'b1, {8'h00, 4'b1010});
    send(OP_SBB, 8'h05, 8'h02, 1'b1, {8'h02, 4'b1000});
    idle();
    drain("drain_directed");

    // Bubbles must leave the last result and flags in place
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bubble_valid", 16'(out_valid), 16'd0);
    check("bubble_hold", {4'h0, s, cout, ovf, zero, neg}, {4'h0, 8'h02, 4'b1000});
    @(posedge clk); #1;

    // Back-to-back random stream
    max_run = 0;
    pop_before = popped;
    for (int i = 0; i < 8; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = 8'($urandom_range(0, 255));
      r_b  = 8'($urandom_range(0, 255));
      r_c  = 1'($urandom_range(0, 1));
      send(r_op, r_a, r_b, r_c, model(r_op, r_a, r_b, r_c));
    end
    idle();
    drain("drain_stream");
    check("stream_run", 16'(max_run), 16'd8);
    check("stream_count", 16'(popped - pop_before), 16'd8);

    // Backpressure: outputs frozen while out_ready is low
    out_ready = 1'b0;
    send(OP_ADD, 8'h10, 8'h20, 1'b0, {8'h30, 4'b0000});
    send(OP_SUB, 8'h20, 8'h30, 1'b0, {8'hF0, 4'b0001});
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", 16'(in_ready), 16'd0);
      check("hold_out_valid", 16'(out_valid), 16'd1);
      check("hold_data", {4'h0, s, cout, ovf, zero, neg}, {4'h0, 8'h30, 4'b0000});
    end
    @(posedge clk); #1;
    pop_before = popped;
    out_ready = 1'b1;
    drain("drain_hold");
    check("hold_count", 16'(popped - pop_before), 16'd2);

    // Reset with two beats in flight discards them
    out_ready = 1'b0;
    send(OP_ADD, 8'h11, 8'h22, 1'b0, model(2'b00, 8'h11, 8'h22, 1'b0));
    send(OP_SUB, 8'h33, 8'h44, 1'b0, model(2'b01, 8'h33, 8'h44, 1'b0));
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst2_out_valid", 16'(out_valid), 16'd0);
    check("rst2_outputs", {4'h0, s, cout, ovf, zero, neg}, 16'h0000);
    check("rst2_in_ready", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    pop_before = popped;
    send(OP_ADD, 8'h01, 8'h01, 1'b0, {8'h02, 4'b0000});
    idle();
    @(negedge clk); check("rst2_lat_edge1", 16'(out_valid), 16'd0);
    @(negedge clk); check("rst2_lat_edge2", 16'(out_valid), 16'd1);
    @(posedge clk); #1;
    drain("drain_after_rst");
    check("rst2_count", 16'(popped - pop_before), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
